if_fetch_unit: RTL and testbench

Instruction-fetch front end that produces the IF2ID bus captured by the IF/ID pipeline register. Owns the fetch PC and issues in-order requests to instruction memory over a valid/ready channel. Buffers returned instructions in a small FIFO so that ID-stage stalls never lose data. Handles redirects from branch/jump resolution by discarding all stale in-flight responses.

---
 rtl/IF2ID_if.sv | 14 +
 rtl/if_fetch_unit.sv | 111 +++++++++++
 tb/tb_if_fetch_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/IF2ID_if.sv
// IF-to-ID bus: one fetched instruction with its PC, qualified by valid.
// The fetch unit drives it; the IF/ID pipeline register samples it.
interface IF2ID_if;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if2id_t;

  if2id_t data;

  modport MASTER (output data);
  modport SLAVE  (input  data);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: in-order requests under a credit limit,
// a small response FIFO, and redirect handling that discards stale responses.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall_i,
  input  logic           redirect_i,
  input  logic [31:0]    redirect_pc_i,
  output logic           imem_req_valid_o,
  input  logic           imem_req_ready_i,
  output logic [31:0]    imem_req_addr_o,
  input  logic           imem_rsp_valid_i,
  input  logic [31:0]    imem_rsp_data_i,
  IF2ID_if.MASTER        bus_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [AW-1:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d;
  logic [CW-1:0] f_cnt_q, f_cnt_d;

  logic [31:0] tag_mem_q  [DEPTH];
  logic [31:0] fifo_pc_q  [DEPTH];
  logic [31:0] fifo_ins_q [DEPTH];

  logic        head_vld, pop, req_fire, rsp_fire, fifo_push;
  logic [CW:0] credit_use;

  // Head is hidden during a redirect so ID never consumes a stale instruction.
  assign head_vld   = (f_cnt_q != '0) && !redirect_i;
  assign pop        = head_vld && !stall_i;
  assign credit_use = {1'b0, out_q} + {1'b0, f_cnt_q} - (CW+1)'(pop);

  assign imem_req_valid_o = !rst && !redirect_i && (credit_use < DEPTH_C);
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign rsp_fire         = imem_rsp_valid_i;
  assign fifo_push        = rsp_fire && !redirect_i && (drop_q == '0);

  assign bus_out.data = head_vld ? {1'b1, fifo_pc_q[f_rd_q], fifo_ins_q[f_rd_q]} : '0;

  always_comb begin
    pc_d     = pc_q;
    drop_d   = drop_q;
    f_wr_d   = f_wr_q;
    f_rd_d   = f_rd_q;
    f_cnt_d  = f_cnt_q;
    tag_wr_d = tag_wr_q + AW'(req_fire);
    tag_rd_d = tag_rd_q + AW'(rsp_fire);
    out_d    = out_q + CW'(req_fire) - CW'(rsp_fire);
    if (req_fire) pc_d = pc_q + 32'd4;
    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      pc_d    = redirect_pc_i;
      drop_d  = out_q - CW'(rsp_fire);
      f_wr_d  = '0;
      f_rd_d  = '0;
      f_cnt_d = '0;
    end else begin
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (fifo_push) f_wr_d = f_wr_q + AW'(1);
      if (pop)       f_rd_d = f_rd_q + AW'(1);
      f_cnt_d = f_cnt_q + CW'(fifo_push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      f_wr_q   <= '0;
      f_rd_q   <= '0;
      f_cnt_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      f_wr_q   <= f_wr_d;
      f_rd_q   <= f_rd_d;
      f_cnt_q  <= f_cnt_d;
    end
  end

  // Storage carries no reset; pointers and counts alone define what is live.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem_q[tag_wr_q] <= pc_q;
    if (fifo_push) begin
      fifo_pc_q[f_wr_q]  <= tag_mem_q[tag_rd_q];
      fifo_ins_q[f_wr_q] <= imem_rsp_data_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && (f_cnt_q == FULL_C)));
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(rsp_fire && (out_q == '0)));
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a queue-based in-order memory model.
module tb_if_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b1;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = 32'h0;

  IF2ID_if bus();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .bus_out          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } ment_t;

  ment_t mq[$];
  int    cyc, lat, checks, errors, issued, popped;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: memory accepts/returns around the edge, inputs settle 2 time units after it.
  task automatic tick();
    logic        fire, rf;
    logic [31:0] a;
    ment_t       e;
    fire = imem_req_valid_o && imem_req_ready_i;
    a    = imem_req_addr_o;
    rf   = imem_rsp_valid_i;
    if (bus.data.valid && !stall_i && !redirect_i) popped++;
    if (fire) issued++;
    @(posedge clk);
    cyc++;
    if (rf && mq.size() > 0) void'(mq.pop_front());
    if (fire) begin
      e.addr = a;
      e.due  = cyc - 1 + lat;
      mq.push_back(e);
    end
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mq[0].addr ^ KEY;
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'h0;
    end
    #1;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = 32'h0;
    mq.delete();
    lat = l;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_vld", 32'(imem_req_valid_o), 32'h0);
    check("rst_req_addr", imem_req_addr_o, 32'h0);
    check("rst_out_vld", 32'(bus.data.valid), 32'h0);
    check("rst_out_pc", bus.data.pc, 32'h0);
    rst = 1'b0;
    cyc = 0;
    issued = 0;
    popped = 0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_out, exp_req;
    int          nout;
    int          n;
    checks = 0;
    errors = 0;

    // Basic fetch, 1-cycle memory
    do_reset(1);
    check("t1_c0_req_vld", 32'(imem_req_valid_o), 32'h1);
    check("t1_c0_req_addr", imem_req_addr_o, 32'h0);
    tick();
    check("t1_c1_req_addr", imem_req_addr_o, 32'h4);
    check("t1_c1_out_vld", 32'(bus.data.valid), 32'h0);
    for (int c = 2; c < 8; c++) begin
      tick();
      check("t1_out_vld", 32'(bus.data.valid), 32'h1);
      check("t1_out_pc", bus.data.pc, 32'((c - 2) * 4));
      check("t1_out_instr", bus.data.instr, 32'((c - 2) * 4) ^ KEY);
      check("t1_req_addr", imem_req_addr_o, 32'(c * 4));
    end

    // Stall hold for 5 cycles at pc 0x8
    do_reset(1);
    repeat (4) tick();
    stall_i = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_vld", 32'(bus.data.valid), 32'h1);
      check("t2_hold_pc", bus.data.pc, 32'h8);
      check("t2_credit", 32'((issued - popped) <= 2), 32'h1);
      tick();
    end
    stall_i = 1'b0;
    #1;
    check("t2_rel0_pc", bus.data.pc, 32'h8);
    tick();
    check("t2_rel1_vld", 32'(bus.data.valid), 32'h1);
    check("t2_rel1_pc", bus.data.pc, 32'hC);
    tick();
    check("t2_rel2_vld", 32'(bus.data.valid), 32'h1);
    check("t2_rel2_pc", bus.data.pc, 32'h10);

    // Redirect with two requests in flight, 3-cycle memory
    do_reset(3);
    tick();
    tick();
    check("t3_inflight", 32'(issued), 32'h2);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    #1;
    check("t3_redir_req_vld", 32'(imem_req_valid_o), 32'h0);
    tick();
    redirect_i = 1'b0;
    #1;
    n = 0;
    while (!bus.data.valid && n < 20) begin
      tick();
      n++;
    end
    check("t3_first_vld", 32'(bus.data.valid), 32'h1);
    check("t3_first_pc", bus.data.pc, 32'h100);
    check("t3_first_instr", bus.data.instr, 32'h100 ^ KEY);
    tick();
    check("t3_second_pc", bus.data.pc, 32'h104);

    // Redirect, response and stall in the same cycle
    do_reset(1);
    repeat (3) tick();
    stall_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    #1;
    check("t4_redir_out_vld", 32'(bus.data.valid), 32'h0);
    check("t4_redir_req_vld", 32'(imem_req_valid_o), 32'h0);
    tick();
    stall_i = 1'b0;
    redirect_i = 1'b0;
    #1;
    check("t4_after_out_vld", 32'(bus.data.valid), 32'h0);
    check("t4_after_req_vld", 32'(imem_req_valid_o), 32'h1);
    check("t4_after_req_addr", imem_req_addr_o, 32'h40);
    tick();
    check("t4_c5_out_vld", 32'(bus.data.valid), 32'h0);
    tick();
    check("t4_c6_out_vld", 32'(bus.data.valid), 32'h1);
    check("t4_c6_out_pc", bus.data.pc, 32'h40);

    // Random backpressure across the address wrap
    do_reset(1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    #1;
    tick();
    redirect_i = 1'b0;
    exp_out = 32'hFFFF_FFF8;
    exp_req = 32'hFFFF_FFF8;
    nout = 0;
    for (int i = 0; i < 60; i++) begin
      imem_req_ready_i = (i % 4 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (imem_req_valid_o && imem_req_ready_i) begin
        check("t5_req_addr", imem_req_addr_o, exp_req);
        exp_req = exp_req + 32'd4;
      end
      if (bus.data.valid && !stall_i) begin
        check("t5_out_pc", bus.data.pc, exp_out);
        check("t5_out_instr", bus.data.instr, exp_out ^ KEY);
        exp_out = exp_out + 32'd4;
        nout++;
      end
      tick();
    end
    check("t5_wrapped", 32'(nout >= 3), 32'h1);

    // Asynchronous reset mid-operation
    do_reset(2);
    stall_i = 1'b1;
    #1;
    repeat (3) tick();
    check("t6_pre_vld", 32'(bus.data.valid), 32'h1);
    check("t6_pre_addr", imem_req_addr_o, 32'h8);
    #3;
    rst = 1'b1;
    #1;
    check("t6_async_req_vld", 32'(imem_req_valid_o), 32'h0);
    check("t6_async_req_addr", imem_req_addr_o, 32'h0);
    check("t6_async_out_vld", 32'(bus.data.valid), 32'h0);
    check("t6_async_out_pc", bus.data.pc, 32'h0);
    check("t6_async_out_instr", bus.data.instr, 32'h0);
    do_reset(1);
    check("t6_restart_req_vld", 32'(imem_req_valid_o), 32'h1);
    check("t6_restart_addr", imem_req_addr_o, 32'h0);
    tick();
    check("t6_restart_c1_vld", 32'(bus.data.valid), 32'h0);
    tick();
    check("t6_restart_c2_vld", 32'(bus.data.valid), 32'h1);
    check("t6_restart_c2_pc", bus.data.pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
